pwm_ramp_seq: RTL and testbench

PWM_RAMP_SEQ -- requirements
Module: pwm_ramp_seq

---
 rtl/pwm_ramp_seq.sv | 158 +++++++++++++++
 tb/tb_pwm_ramp_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_seq.sv
// pwm_ramp_seq
// Ramps the duty value presented to a 50-cycle PWM generator toward a
// requested target, one step of 1 every 2^rate PWM periods. The duty value
// only changes on the period boundary, so the generator never sees a partial
// period.
//
// Optional feature macro: PWM_SEQ_SATURATE_EN
//    defined   : targets above 50 are clamped to 50, err is never raised
//    undefined : targets above 50 are rejected with a one-cycle err pulse
//
// Ports
//    clock        in   1  sole clock, rising edge
//    reset        in   1  synchronous, active-low
//    tgt_duty     in   6  requested target duty (high cycles per period)
//    tgt_rate     in   2  one duty step every 2^tgt_rate periods
//    tgt_valid    in   1  target request
//    tgt_ready    out  1  request can be accepted (sequencer idle)
//    duty_out     out  6  duty presented to the PWM generator
//    period_start out  1  high on the first cycle of each PWM period
//    busy         out  1  high while ramping
//    done         out  1  one-cycle pulse when duty_out reaches target
//    err          out  1  one-cycle pulse on a rejected target
module pwm_ramp_seq (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] tgt_duty,
   input  logic [1:0] tgt_rate,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   output logic [5:0] duty_out,
   output logic       period_start,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [5:0] PER_LAST = 6'd49;
   localparam logic [5:0] DUTY_MAX = 6'd50;

   typedef enum logic {IDLE, RAMP} state_t;

   state_t     state_q, state_d;
   logic [5:0] per_cnt_q, per_cnt_d;
   logic [5:0] duty_q, duty_d;
   logic [5:0] target_q, target_d;
   logic [1:0] rate_q, rate_d;
   logic [2:0] div_q, div_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       wrap;
   logic [2:0] div_last;
   logic [5:0] duty_step;
   logic [5:0] tgt_eff;
   logic       tgt_reject;

   // Out-of-range targets are either clamped or rejected depending on build.
`ifdef PWM_SEQ_SATURATE_EN
   assign tgt_eff    = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
   assign tgt_reject = 1'b0;
`else
   assign tgt_eff    = tgt_duty;
   assign tgt_reject = (tgt_duty > DUTY_MAX);
`endif

   assign wrap      = (per_cnt_q == PER_LAST);
   assign duty_step = (target_q > duty_q) ? (duty_q + 6'd1) : (duty_q - 6'd1);

   // Last divider value before a step is taken: 2^rate wraps per step.
   always_comb begin
      div_last = 3'd0;
      case (rate_q)
         2'd0:    div_last = 3'd0;
         2'd1:    div_last = 3'd1;
         2'd2:    div_last = 3'd3;
         default: div_last = 3'd7;
      endcase
   end

   // Next-state logic. The divider counts period wraps while ramping; duty
   // moves only on a wrap edge, and the edge that lands on the target also
   // returns to IDLE and arms the done pulse for exactly one cycle.
   always_comb begin
      state_d   = state_q;
      per_cnt_d = wrap ? 6'd0 : (per_cnt_q + 6'd1);
      duty_d    = duty_q;
      target_d  = target_q;
      rate_d    = rate_q;
      div_d     = div_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tgt_valid) begin
               if (tgt_reject) begin
                  err_d = 1'b1;
               end else if (tgt_eff == duty_q) begin
                  done_d = 1'b1;
               end else begin
                  target_d = tgt_eff;
                  rate_d   = tgt_rate;
                  div_d    = 3'd0;
                  state_d  = RAMP;
               end
            end
         end
         RAMP: begin
            if (wrap) begin
               if (div_q == div_last) begin
                  div_d  = 3'd0;
                  duty_d = duty_step;
                  if (duty_step == target_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  div_d = div_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset abandons any
   // ramp in progress without a done pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         per_cnt_q <= 6'd0;
         duty_q    <= 6'd0;
         target_q  <= 6'd0;
         rate_q    <= 2'd0;
         div_q     <= 3'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         duty_q    <= duty_d;
         target_q  <= target_d;
         rate_q    <= rate_d;
         div_q     <= div_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign tgt_ready    = (state_q == IDLE);
   assign busy         = (state_q == RAMP);
   assign period_start = (per_cnt_q == 6'd0);
   assign duty_out     = duty_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// tb_pwm_ramp_seq
// Directed bench for pwm_ramp_seq: reset state, up/down ramps at rates 0 and
// 1, equal-target handshake, out-of-range target (build dependent on
// PWM_SEQ_SATURATE_EN), ignored requests mid-ramp and reset mid-ramp.
module tb_pwm_ramp_seq;

   logic       clock;
   logic       reset;
   logic [5:0] tgt_duty;
   logic [1:0] tgt_rate;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [5:0] duty_out;
   logic       period_start;
   logic       busy;
   logic       done;
   logic       err;

   int total;
   int bad;
   int done_cnt;
   int err_cnt;

   pwm_ramp_seq dut (
      .clock        (clock),
      .reset        (reset),
      .tgt_duty     (tgt_duty),
      .tgt_rate     (tgt_rate),
      .tgt_valid    (tgt_valid),
      .tgt_ready    (tgt_ready),
      .duty_out     (duty_out),
      .period_start (period_start),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one cycle and observe just after the edge; pulses are counted
   // here so every cycle is seen.
   task automatic tick();
      @(posedge clock);
      #1;
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] duty, input logic [1:0] rate);
      tgt_duty  = duty;
      tgt_rate  = rate;
      tgt_valid = 1'b1;
   endtask

   // Step until the first cycle of a period is observed (bounded).
   task automatic align();
      int n;
      n = 0;
      while (period_start !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("align", {7'd0, period_start}, 8'd1);
   endtask

   // Request drv at rate and follow the ramp from start to fin, checking the
   // held value before every step edge and the new value after it. With
   // inject set, a tgt 20 request is held during the 5th step interval.
   task automatic ramp(input logic [5:0] drv, input logic [5:0] fin, input logic [1:0] rate,
                       input logic [5:0] start, input bit inject);
      int d, n, per, k, dsnap, esnap;
      bit first;
      align();
      dsnap = done_cnt;
      esnap = err_cnt;
      applyStimulus(drv, rate);
      tick();
      tgt_valid = 1'b0;
      checkOutput("busy_after_accept", {7'd0, busy}, 8'd1);
      checkOutput("ready_after_accept", {7'd0, tgt_ready}, 8'd0);
      d     = start;
      first = 1'b1;
      per   = 50 << rate;
      k     = 0;
      while (d != fin) begin
         k++;
         n     = first ? per - 1 : per;
         first = 1'b0;
         if (inject && k == 5) applyStimulus(6'd20, 2'd0);
         repeat (n - 1) tick();
         tgt_valid = 1'b0;
         checkOutput("duty_hold", {2'd0, duty_out}, d[7:0]);
         checkOutput("busy_hold", {7'd0, busy}, 8'd1);
         tick();
         d = (fin > d) ? d + 1 : d - 1;
         checkOutput("duty_step", {2'd0, duty_out}, d[7:0]);
         checkOutput("pstart_step", {7'd0, period_start}, 8'd1);
      end
      checkOutput("done_at_target", {7'd0, done}, 8'd1);
      checkOutput("busy_at_target", {7'd0, busy}, 8'd0);
      tick();
      checkOutput("done_drop", {7'd0, done}, 8'd0);
      checkOutput("done_once", 8'(done_cnt - dsnap), 8'd1);
      checkOutput("no_err_ramp", 8'(err_cnt - esnap), 8'd0);
   endtask

   initial begin
      int n, dsnap, esnap;
      total     = 0;
      bad       = 0;
      done_cnt  = 0;
      err_cnt   = 0;
      reset     = 1'b0;
      tgt_duty  = 6'd0;
      tgt_rate  = 2'd0;
      tgt_valid = 1'b0;

      // Reset state, then first cycle after release
      repeat (3) tick();
      checkOutput("rst_duty", {2'd0, duty_out}, 8'd0);
      checkOutput("rst_pstart", {7'd0, period_start}, 8'd1);
      checkOutput("rst_done", {7'd0, done}, 8'd0);
      checkOutput("rst_err", {7'd0, err}, 8'd0);
      reset = 1'b1;
      checkOutput("rel_pstart", {7'd0, period_start}, 8'd1);
      checkOutput("rel_ready", {7'd0, tgt_ready}, 8'd1);
      checkOutput("rel_busy", {7'd0, busy}, 8'd0);
      checkOutput("rel_duty", {2'd0, duty_out}, 8'd0);

      // Ramp 0 -> 10 at rate 0, with an ignored tgt 20 request mid-ramp
      $display("[TB] ramp 0->10 rate 0 with ignored request");
      ramp(6'd10, 6'd10, 2'd0, 6'd0, 1'b1);

      // Down to 4, then 4 -> 1 at rate 1 (one step per 100 cycles)
      $display("[TB] ramp 10->4, then 4->1 rate 1");
      ramp(6'd4, 6'd4, 2'd0, 6'd10, 1'b0);
      ramp(6'd1, 6'd1, 2'd1, 6'd4, 1'b0);

      // Target equal to current duty 7
      $display("[TB] equal target");
      ramp(6'd7, 6'd7, 2'd0, 6'd1, 1'b0);
      dsnap = done_cnt;
      applyStimulus(6'd7, 2'd0);
      tick();
      tgt_valid = 1'b0;
      checkOutput("eq_done", {7'd0, done}, 8'd1);
      checkOutput("eq_busy", {7'd0, busy}, 8'd0);
      checkOutput("eq_duty", {2'd0, duty_out}, 8'd7);
      tick();
      checkOutput("eq_done_drop", {7'd0, done}, 8'd0);
      checkOutput("eq_done_once", 8'(done_cnt - dsnap), 8'd1);

      // Out-of-range target 60
      $display("[TB] out-of-range target");
`ifdef PWM_SEQ_SATURATE_EN
      ramp(6'd60, 6'd50, 2'd0, 6'd7, 1'b0);
      repeat (60) tick();
      checkOutput("sat_duty_hold", {2'd0, duty_out}, 8'd50);
      checkOutput("sat_no_err", 8'(err_cnt), 8'd0);
`else
      dsnap = done_cnt;
      esnap = err_cnt;
      applyStimulus(6'd60, 2'd0);
      tick();
      tgt_valid = 1'b0;
      checkOutput("rej_err", {7'd0, err}, 8'd1);
      checkOutput("rej_done", {7'd0, done}, 8'd0);
      checkOutput("rej_busy", {7'd0, busy}, 8'd0);
      checkOutput("rej_duty", {2'd0, duty_out}, 8'd7);
      tick();
      checkOutput("rej_err_drop", {7'd0, err}, 8'd0);
      repeat (60) tick();
      checkOutput("rej_duty_hold", {2'd0, duty_out}, 8'd7);
      checkOutput("rej_err_once", 8'(err_cnt - esnap), 8'd1);
      checkOutput("rej_no_done", 8'(done_cnt - dsnap), 8'd0);
`endif

      // Reset mid-ramp at duty 5 while heading to 0
      $display("[TB] reset mid-ramp");
      applyStimulus(6'd0, 2'd0);
      tick();
      tgt_valid = 1'b0;
      n = 0;
      while (duty_out !== 6'd5 && n < 5000) begin
         tick();
         n++;
      end
      checkOutput("reach_duty5", {2'd0, duty_out}, 8'd5);
      repeat (20) tick();
      dsnap = done_cnt;
      reset = 1'b0;
      applyStimulus(6'd9, 2'd0);
      tick();
      tgt_valid = 1'b0;
      checkOutput("mid_rst_duty", {2'd0, duty_out}, 8'd0);
      checkOutput("mid_rst_busy", {7'd0, busy}, 8'd0);
      reset = 1'b1;
      checkOutput("mid_rel_pstart", {7'd0, period_start}, 8'd1);
      checkOutput("mid_rel_ready", {7'd0, tgt_ready}, 8'd1);
      checkOutput("mid_rel_duty", {2'd0, duty_out}, 8'd0);
      repeat (120) tick();
      checkOutput("mid_no_done", 8'(done_cnt - dsnap), 8'd0);
      checkOutput("mid_duty_stay", {2'd0, duty_out}, 8'd0);
      checkOutput("mid_busy_stay", {7'd0, busy}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
